aha_clk_en_selector: RTL

//  Consumes the six divided-clock enables (/1,/2,/4,/8,/16,/32) from the clock divider.

---
 rtl/aha_clk_pkg.sv | 20 ++
 rtl/aha_clk_en_mux.sv | 18 +
 rtl/aha_clk_en_selector.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/aha_clk_pkg.sv
// Shared types and constants for the divided-clock enable selector.
package aha_clk_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WAIT_BND = 2'd1,
      ACK      = 2'd2
   } state_t;

   localparam int unsigned AHA_NUM_DIV   = 6;
   localparam int unsigned AHA_DIV_SEL_W = 3;

   localparam int unsigned AHA_DIV_BY1  = 0;
   localparam int unsigned AHA_DIV_BY2  = 1;
   localparam int unsigned AHA_DIV_BY4  = 2;
   localparam int unsigned AHA_DIV_BY8  = 3;
   localparam int unsigned AHA_DIV_BY16 = 4;
   localparam int unsigned AHA_DIV_BY32 = 5;

endpackage

// File: rtl/aha_clk_en_mux.sv
// Indexed enable mux: one-hot decode of the select, AND-OR into one enable.
module aha_clk_en_mux #(
   parameter int unsigned N     = 6,
   parameter int unsigned SEL_W = 3
) (
   input  logic [N-1:0]     i_en,
   input  logic [SEL_W-1:0] i_sel,
   output logic             o_en_c
);

   always_comb begin
      o_en_c = 1'b0;
      for (int unsigned i = 0; i < N; i++) begin
         o_en_c = o_en_c | (i_en[i] & (i_sel == SEL_W'(i)));
      end
   end

endmodule

// File: rtl/aha_clk_en_selector.sv
// Selects one divided clock enable for the downstream ICG; ratio changes land on a /32 boundary.
// Optional switch counter output enabled by defining AHA_CLK_EN_SEL_STATS_EN.
module aha_clk_en_selector
   import aha_clk_pkg::*;
#(
   parameter int unsigned NUM_DIV   = AHA_NUM_DIV,
   parameter int unsigned SEL_W     = AHA_DIV_SEL_W,
   parameter int unsigned RESET_SEL = AHA_DIV_BY1
) (
   input  logic               CLK,
   input  logic               RESETn,
   input  logic [NUM_DIV-1:0] EN_IN,
   input  logic               SEL_REQ,
   input  logic [SEL_W-1:0]   SEL_VAL,
   output logic               SEL_ACK,
   output logic               SEL_ERR,
   output logic               CLK_EN_OUT,
   output logic [SEL_W-1:0]   CUR_SEL,
   output logic               BUSY
`ifdef AHA_CLK_EN_SEL_STATS_EN
   ,
   output logic [15:0]        SWITCH_CNT
`endif
);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [SEL_W-1:0] r_cur_sel;
   logic [SEL_W-1:0] r_pend_sel;
   logic             r_ack;
   logic             r_err;
   logic             r_busy;

   logic             w_bnd;
   logic             w_sel_bad;
   logic             w_sel_same;
   logic             w_ack_nxt;
   logic             w_err_nxt;
   logic             w_busy_nxt;
   logic             w_pend_ld;
   logic             w_apply;
   logic             w_clk_en;

   // Input contract guarantees every enable is high when the slowest one is.
   assign w_bnd      = EN_IN[NUM_DIV-1];
   assign w_sel_bad  = 32'(SEL_VAL) >= NUM_DIV;
   assign w_sel_same = (SEL_VAL == r_cur_sel);

   // State register
   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE: begin
            if (SEL_REQ) begin
               if (w_sel_bad || w_sel_same) begin
                  w_state_nxt = ACK;
               end else begin
                  w_state_nxt = WAIT_BND;
               end
            end
         end
         WAIT_BND: begin
            if (w_bnd) begin
               w_state_nxt = ACK;
            end
         end
         ACK:     w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // Output/datapath next values; all of them are registered below
   always_comb begin
      w_ack_nxt  = 1'b0;
      w_err_nxt  = 1'b0;
      w_busy_nxt = 1'b0;
      w_pend_ld  = 1'b0;
      w_apply    = 1'b0;
      case (r_state)
         IDLE: begin
            if (SEL_REQ) begin
               w_busy_nxt = 1'b1;
               if (w_sel_bad) begin
                  w_ack_nxt = 1'b1;
                  w_err_nxt = 1'b1;
               end else if (w_sel_same) begin
                  w_ack_nxt = 1'b1;
               end else begin
                  w_pend_ld = 1'b1;
               end
            end
         end
         WAIT_BND: begin
            w_busy_nxt = 1'b1;
            if (w_bnd) begin
               w_ack_nxt = 1'b1;
               w_apply   = 1'b1;
            end
         end
         default: ;
      endcase
   end

   // The boundary cycle still uses the old select; the new one applies from the next cycle
   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         r_cur_sel  <= SEL_W'(RESET_SEL);
         r_pend_sel <= SEL_W'(RESET_SEL);
         r_ack      <= 1'b0;
         r_err      <= 1'b0;
         r_busy     <= 1'b0;
      end else begin
         r_ack  <= w_ack_nxt;
         r_err  <= w_err_nxt;
         r_busy <= w_busy_nxt;
         if (w_pend_ld) begin
            r_pend_sel <= SEL_VAL;
         end
         if (w_apply) begin
            r_cur_sel <= r_pend_sel;
         end
      end
   end

`ifdef AHA_CLK_EN_SEL_STATS_EN
   logic [15:0] r_switch_cnt;

   // Saturating count of applied ratio changes
   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         r_switch_cnt <= 16'd0;
      end else if (w_apply && (r_pend_sel != r_cur_sel) && (r_switch_cnt != 16'hFFFF)) begin
         r_switch_cnt <= r_switch_cnt + 16'd1;
      end
   end

   assign SWITCH_CNT = r_switch_cnt;
`endif

   aha_clk_en_mux #(
      .N     (NUM_DIV),
      .SEL_W (SEL_W)
   ) u_en_mux (
      .i_en   (EN_IN),
      .i_sel  (r_cur_sel),
      .o_en_c (w_clk_en)
   );

   assign CLK_EN_OUT = w_clk_en;
   assign SEL_ACK    = r_ack;
   assign SEL_ERR    = r_err;
   assign CUR_SEL    = r_cur_sel;
   assign BUSY       = r_busy;

endmodule
